// File: rtl/aurora_frame_gen.sv
// Aurora TX frame generator: header word plus LFSR payload on a 32-bit AXI4-Stream
// user interface, with a programmable idle gap between frames and abort on channel loss.
module aurora_frame_gen #(
  parameter int unsigned MAX_WORDS  = 64,
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hABE1
) (
  input  logic        USER_CLK,
  input  logic        RESET_N,
  input  logic        CHANNEL_UP,
  input  logic        ENABLE,
  input  logic [7:0]  FRAME_LEN,
  input  logic [0:3]  LAST_KEEP,
  output logic [0:31] tx_data,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic [0:3]  tx_tkeep,
  output logic        tx_tlast,
  output logic        frame_start,
  output logic        busy,
  output logic [31:0] frame_count
);

  typedef enum logic [1:0] {StIdle, StHdr, StPay, StGap} state_e;

  localparam logic [7:0] MaxLen = 8'(MAX_WORDS);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e          r_state, w_state_nxt;
  logic [15:0]     r_lfsr, w_lfsr_nxt;
  logic [7:0]      r_seq, w_seq_nxt;
  logic [7:0]      r_len, w_len_nxt;
  logic [7:0]      r_beat, w_beat_nxt;
  logic [GapW-1:0] r_gap, w_gap_nxt;
  logic [31:0]     r_count, w_count_nxt;
  logic [31:0]     r_data, w_data_nxt;
  logic [3:0]      r_keep, w_keep_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_last, w_last_nxt;
  logic            r_fs, w_fs_nxt;
  logic            r_busy, w_busy_nxt;

  logic            w_hs;
  logic [15:0]     w_lfsr_step;
  logic [7:0]      w_len;
  logic [3:0]      w_last_keep;
  logic            w_next_is_last;

  assign w_hs        = r_valid & tx_tready;
  // x^16 + x^15 + x^13 + x^4 + 1, shifting left, feedback into bit 0
  assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3]};
  assign w_last_keep = (LAST_KEEP == 4'h0) ? 4'hF : LAST_KEEP;
  assign w_next_is_last = ((r_beat + 8'd1) == r_len);

  // Clamp the requested payload length into 1..MAX_WORDS
  always_comb begin
    if (FRAME_LEN == 8'd0) begin
      w_len = 8'd1;
    end else if (FRAME_LEN > MaxLen) begin
      w_len = MaxLen;
    end else begin
      w_len = FRAME_LEN;
    end
  end

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_seq_nxt   = r_seq;
    w_len_nxt   = r_len;
    w_beat_nxt  = r_beat;
    w_gap_nxt   = r_gap;
    w_count_nxt = r_count;
    w_data_nxt  = r_data;
    w_keep_nxt  = r_keep;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;
    w_fs_nxt    = 1'b0;

    if (r_state != StIdle && !CHANNEL_UP) begin
      // Abort: a tlast accepted on this same edge still counts
      if (r_state == StPay && w_hs && r_last) begin
        w_count_nxt = r_count + 32'd1;
        w_seq_nxt   = r_seq + 8'd1;
      end
      w_state_nxt = StIdle;
      w_lfsr_nxt  = LFSR_SEED;
      w_valid_nxt = 1'b0;
      w_data_nxt  = 32'h0;
      w_keep_nxt  = 4'h0;
      w_last_nxt  = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (ENABLE && CHANNEL_UP) begin
            w_state_nxt = StHdr;
            w_len_nxt   = w_len;
            w_valid_nxt = 1'b1;
            w_data_nxt  = {8'hA5, r_seq, 8'h00, w_len};
            w_keep_nxt  = 4'hF;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b1;
          end
        end
        StHdr: begin
          if (w_hs) begin
            w_state_nxt = StPay;
            w_fs_nxt    = 1'b1;
            w_beat_nxt  = 8'd1;
            w_data_nxt  = {r_lfsr, ~r_lfsr};
            w_last_nxt  = (r_len == 8'd1);
            w_keep_nxt  = (r_len == 8'd1) ? w_last_keep : 4'hF;
          end
        end
        StPay: begin
          if (w_hs) begin
            w_lfsr_nxt = w_lfsr_step;
            if (r_last) begin
              w_count_nxt = r_count + 32'd1;
              w_seq_nxt   = r_seq + 8'd1;
              w_valid_nxt = 1'b0;
              w_data_nxt  = 32'h0;
              w_keep_nxt  = 4'h0;
              w_last_nxt  = 1'b0;
              w_gap_nxt   = '0;
              if (GAP_CYCLES == 0) begin
                w_state_nxt = StIdle;
                w_busy_nxt  = 1'b0;
              end else begin
                w_state_nxt = StGap;
              end
            end else begin
              w_beat_nxt = r_beat + 8'd1;
              w_data_nxt = {w_lfsr_step, ~w_lfsr_step};
              w_last_nxt = w_next_is_last;
              w_keep_nxt = w_next_is_last ? w_last_keep : 4'hF;
            end
          end
        end
        StGap: begin
          if (r_gap == GapLast) begin
            w_state_nxt = StIdle;
            w_busy_nxt  = 1'b0;
          end else begin
            w_gap_nxt = r_gap + 1'b1;
          end
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= StIdle;
      r_lfsr  <= LFSR_SEED;
      r_seq   <= 8'd0;
      r_len   <= 8'd0;
      r_beat  <= 8'd0;
      r_gap   <= '0;
      r_count <= 32'd0;
      r_data  <= 32'h0;
      r_keep  <= 4'h0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_fs    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_seq   <= w_seq_nxt;
      r_len   <= w_len_nxt;
      r_beat  <= w_beat_nxt;
      r_gap   <= w_gap_nxt;
      r_count <= w_count_nxt;
      r_data  <= w_data_nxt;
      r_keep  <= w_keep_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_fs    <= w_fs_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign tx_data     = r_data;
  assign tx_tvalid   = r_valid;
  assign tx_tkeep    = r_keep;
  assign tx_tlast    = r_last;
  assign frame_start = r_fs;
  assign busy        = r_busy;
  assign frame_count = r_count;

endmodule

// File: tb/tb_aurora_frame_gen.sv
// Bench for aurora_frame_gen: table of frame lengths, random frames with backpressure
// against a frame-level model, plus abort, enable-drop, seq wrap and async reset sequences.
module tb_aurora_frame_gen;

  localparam int unsigned MaxWords  = 64;
  localparam int unsigned GapCycles = 4;
  localparam logic [15:0] Seed      = 16'hABE1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chan_up;
  logic        enable;
  logic [7:0]  frame_len;
  logic [0:3]  last_keep;
  logic [0:31] tx_data;
  logic        tx_tvalid;
  logic        tready;
  logic [0:3]  tx_tkeep;
  logic        tx_tlast;
  logic        frame_start;
  logic        busy;
  logic [31:0] frame_count;

  always #5 clk = ~clk;

  aurora_frame_gen #(
    .MAX_WORDS (MaxWords),
    .GAP_CYCLES(GapCycles),
    .LFSR_SEED (Seed)
  ) dut (
    .USER_CLK   (clk),
    .RESET_N    (rst_n),
    .CHANNEL_UP (chan_up),
    .ENABLE     (enable),
    .FRAME_LEN  (frame_len),
    .LAST_KEEP  (last_keep),
    .tx_data    (tx_data),
    .tx_tvalid  (tx_tvalid),
    .tx_tready  (tready),
    .tx_tkeep   (tx_tkeep),
    .tx_tlast   (tx_tlast),
    .frame_start(frame_start),
    .busy       (busy),
    .frame_count(frame_count)
  );

  typedef struct {
    logic [7:0] len;
    logic [3:0] keep;
    logic [7:0] exp_n;
    logic [3:0] exp_keep;
  } vec_t;

  vec_t vecs[7];

  int total = 0;
  int bad   = 0;

  // Frame-level model state
  logic [15:0] m_lfsr;
  logic [7:0]  m_seq;
  logic [31:0] m_count;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[14] ^ x[12] ^ x[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits for the next accepted beat; checks AXI hold rules while stalled
  task automatic wait_beat(input bit bp, output logic [31:0] d, output logic [3:0] k,
                           output logic l, output int idle, output logic fs0);
    logic [31:0] hd;
    logic [3:0]  hk;
    logic        hl;
    bit          have;
    bit          got;
    idle = 0; have = 0; got = 0;
    d = '0; k = '0; l = 1'b0; fs0 = 1'b0;
    hd = '0; hk = '0; hl = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (c == 0) fs0 = frame_start;
      tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!tx_tvalid) begin
        if (have) check("valid_held", 32'(tx_tvalid), 32'd1);
        have = 0;
        idle++;
      end else begin
        if (have) begin
          check("hold_data", 32'(tx_data), hd);
          check("hold_keep", 32'(tx_tkeep), 32'(hk));
          check("hold_last", 32'(tx_tlast), 32'(hl));
        end
        hd = tx_data; hk = tx_tkeep; hl = tx_tlast;
        have = 1;
        if (tready) begin
          d = hd; k = hk; l = hl;
          got = 1;
        end
      end
    end
    if (!got) check("beat_timeout", 32'(got), 32'd1);
  endtask

  // Runs one full frame; exp_idle < 0 skips the idle-gap check
  task automatic run_frame(input logic [7:0] len, input logic [3:0] keep_in,
                           input logic [7:0] exp_n, input logic [3:0] exp_keep,
                           input bit bp, input int exp_idle, input bit drop_en);
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    int          idle;
    logic        fs;
    frame_len = len;
    last_keep = keep_in;
    wait_beat(bp, d, k, l, idle, fs);
    check("hdr_data", d, {8'hA5, m_seq, 8'h00, exp_n});
    check("hdr_keep", 32'(k), 32'hF);
    check("hdr_last", 32'(l), 32'd0);
    if (exp_idle >= 0) check("idle_gap", 32'(idle), 32'(exp_idle));
    if (drop_en) enable = 1'b0;
    for (int i = 1; i <= int'(exp_n); i++) begin
      wait_beat(bp, d, k, l, idle, fs);
      if (i == 1) check("frame_start", 32'(fs), 32'd1);
      check("pay_data", d, {m_lfsr, ~m_lfsr});
      check("pay_keep", 32'(k), (i == int'(exp_n)) ? 32'(exp_keep) : 32'hF);
      check("pay_last", 32'(l), (i == int'(exp_n)) ? 32'd1 : 32'd0);
      m_lfsr = lfsr_step(m_lfsr);
    end
    m_count++;
    m_seq++;
    @(negedge clk);
    tready = 1'b1;
    check("frame_count", frame_count, m_count);
    check("post_valid", 32'(tx_tvalid), 32'd0);
    check("gap_busy", 32'(busy), (GapCycles != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", 32'(tx_tvalid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_keep", 32'(tx_tkeep), 32'd0);
    check("rst_last", 32'(tx_tlast), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", frame_count, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    int          idle;
    logic        fs;
    logic [7:0]  rl;
    logic [3:0]  rk;
    logic [7:0]  rn;
    int          hi_cnt;

    vecs[0] = '{len: 8'd4,   keep: 4'h0, exp_n: 8'd4,  exp_keep: 4'hF};
    vecs[1] = '{len: 8'd0,   keep: 4'h0, exp_n: 8'd1,  exp_keep: 4'hF};
    vecs[2] = '{len: 8'd200, keep: 4'h0, exp_n: 8'h40, exp_keep: 4'hF};
    vecs[3] = '{len: 8'd5,   keep: 4'hC, exp_n: 8'd5,  exp_keep: 4'hC};
    vecs[4] = '{len: 8'd1,   keep: 4'h3, exp_n: 8'd1,  exp_keep: 4'h3};
    vecs[5] = '{len: 8'd65,  keep: 4'h8, exp_n: 8'd64, exp_keep: 4'h8};
    vecs[6] = '{len: 8'd64,  keep: 4'h0, exp_n: 8'd64, exp_keep: 4'hF};

    rst_n = 1'b0; chan_up = 1'b1; enable = 1'b0; tready = 1'b1;
    frame_len = 8'd4; last_keep = 4'h0;
    m_lfsr = Seed; m_seq = 8'd0; m_count = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_enable", 32'(tx_tvalid), 32'd0);

    // Table-driven frames, tready held high
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].len, vecs[i].keep, vecs[i].exp_n, vecs[i].exp_keep, 1'b0,
                (i == 0) ? 0 : int'(GapCycles), 1'b0);
    end

    // Random frames with random backpressure
    for (int i = 0; i < 20; i++) begin
      rl = 8'($urandom_range(0, 255));
      rk = 4'($urandom_range(0, 15));
      rn = (rl == 8'd0) ? 8'd1 : ((rl > 8'(MaxWords)) ? 8'(MaxWords) : rl);
      run_frame(rl, rk, rn, (rk == 4'h0) ? 4'hF : rk, 1'b1, int'(GapCycles), 1'b0);
    end

    // Abort on payload beat 2
    frame_len = 8'd8; last_keep = 4'h0;
    wait_beat(1'b0, d, k, l, idle, fs);
    check("abort_hdr", d, {8'hA5, m_seq, 8'h00, 8'd8});
    wait_beat(1'b0, d, k, l, idle, fs);
    check("abort_beat1", d, {m_lfsr, ~m_lfsr});
    m_lfsr = lfsr_step(m_lfsr);
    @(negedge clk);
    check("abort_beat2_valid", 32'(tx_tvalid), 32'd1);
    chan_up = 1'b0; tready = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(tx_tvalid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", frame_count, m_count);
    m_lfsr = Seed;
    chan_up = 1'b1;
    run_frame(8'd4, 4'h0, 8'd4, 4'hF, 1'b0, 0, 1'b0);

    // Channel drop on the same edge as tlast acceptance: the frame counts
    frame_len = 8'd1; last_keep = 4'h0;
    wait_beat(1'b0, d, k, l, idle, fs);
    check("tl_abort_hdr", d, {8'hA5, m_seq, 8'h00, 8'd1});
    @(negedge clk);
    check("tl_abort_last", 32'(tx_tlast), 32'd1);
    check("tl_abort_data", 32'(tx_data), {m_lfsr, ~m_lfsr});
    chan_up = 1'b0; tready = 1'b1;
    @(negedge clk);
    m_count++; m_seq++;
    check("tl_abort_count", frame_count, m_count);
    check("tl_abort_valid", 32'(tx_tvalid), 32'd0);
    m_lfsr = Seed;
    chan_up = 1'b1;
    run_frame(8'd3, 4'h0, 8'd3, 4'hF, 1'b0, 0, 1'b0);

    // ENABLE falling mid-frame lets the frame finish, then stays idle
    run_frame(8'd3, 4'h6, 8'd3, 4'h6, 1'b0, int'(GapCycles), 1'b1);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_tvalid) hi_cnt++;
    end
    check("en_drop_quiet", 32'(hi_cnt), 32'd0);
    enable = 1'b1;

    // Enough frames to wrap seq past 255
    for (int i = 0; i < 260; i++) begin
      run_frame(8'd1, 4'h0, 8'd1, 4'hF, 1'b0, (i == 0) ? 0 : int'(GapCycles), 1'b0);
    end

    // Asynchronous reset mid-frame
    frame_len = 8'd10;
    wait_beat(1'b0, d, k, l, idle, fs);
    check("rst_mid_hdr", d, {8'hA5, m_seq, 8'h00, 8'd10});
    wait_beat(1'b0, d, k, l, idle, fs);
    check("rst_mid_beat1", d, {m_lfsr, ~m_lfsr});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = Seed; m_seq = 8'd0; m_count = 32'd0;
    run_frame(8'd4, 4'h0, 8'd4, 4'hF, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
